fft_frame_ctrl: RTL and testbench

Frame scheduler between the ADC SPI front end and the FFT core. It gates the 8-deep sample shift register so that it captures exactly one frame of N accepted ADC samples, with optional decimation. It then freezes the frame, issues a one-cycle start pulse to the FFT core and waits for completion or a timeout. It also accounts for samples dropped while the FFT is busy. Inputs come from the ADC interface's data-valid strobe; outputs drive the shift register enable and the FFT start handshake.

---
 rtl/fft_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frame scheduler between the ADC SPI front end and the FFT core.
//   Gates the sample shift register so it captures one frame of N_SAMPLES
//   accepted ADC samples (one out of every DECIM adc_dv strobes), then
//   freezes the frame, pulses fft_start and waits for fft_done or a timeout.
//   Strobes arriving while the FFT is busy are counted as drops.
//
// Parameters
//   N_SAMPLES  samples per frame, power of two, 2..256
//   DECIM      accept one of every DECIM adc_dv strobes, 1..256
//   TIMEOUT    maximum cycles spent waiting for fft_done, >= 2
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   arm          level, starts a capture from idle
//   continuous   level, sampled at frame end: 1 refills, 0 returns to idle
//   abort        forces idle on the next cycle
//   clear_err    clears overrun and timeout_err
//   adc_dv       ADC data-valid strobe
//   fft_done     FFT completion pulse
//   shift_en     shift-register enable (combinational)
//   fft_start    one-cycle FFT start pulse
//   busy         high whenever not idle
//   sample_idx   samples accepted in the current frame
//   frame_cnt    completed frames (wrapping)
//   drop_cnt     strobes lost while the FFT is busy (saturating)
//   overrun      sticky drop flag
//   timeout_err  sticky timeout flag
module fft_frame_ctrl #(
   parameter int unsigned N_SAMPLES = 8,
   parameter int unsigned DECIM     = 1,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arm,
   input  logic                         continuous,
   input  logic                         abort,
   input  logic                         clear_err,
   input  logic                         adc_dv,
   input  logic                         fft_done,
   output logic                         shift_en,
   output logic                         fft_start,
   output logic                         busy,
   output logic [$clog2(N_SAMPLES)-1:0] sample_idx,
   output logic [7:0]                   frame_cnt,
   output logic [7:0]                   drop_cnt,
   output logic                         overrun,
   output logic                         timeout_err
);

   localparam int unsigned IDX_W = $clog2(N_SAMPLES);
   localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned WT_W  = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_START,
      ST_WAIT
   } state_t;

   state_t            state, state_nxt;
   logic [DEC_W-1:0]  dec_cnt;
   logic [WT_W-1:0]   wait_cnt;

   logic dec_match;
   logic accept;
   logic last_sample;
   logic drop;
   logic done_hit;
   logic to_hit;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:  if (arm) state_nxt = ST_FILL;
            ST_FILL:  if (accept && last_sample) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
               if (fft_done) begin
                  state_nxt = continuous ? ST_FILL : ST_IDLE;
               end else if (to_hit) begin
                  state_nxt = ST_IDLE;
               end
            end
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output / event decode
   always_comb begin
      dec_match   = (dec_cnt == DEC_W'(DECIM - 1));
      last_sample = (sample_idx == IDX_W'(N_SAMPLES - 1));
      accept      = !rst && !abort && (state == ST_FILL) && adc_dv && dec_match;
      shift_en    = accept;
      drop        = !abort && adc_dv && ((state == ST_START) || (state == ST_WAIT));
      done_hit    = !abort && (state == ST_WAIT) && fft_done;
      // fft_done takes precedence over an expiring timeout in the same cycle
      to_hit      = (state == ST_WAIT) && !fft_done && (wait_cnt == WT_W'(TIMEOUT - 1));
   end

   // Registered outputs and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         fft_start   <= 1'b0;
         busy        <= 1'b0;
         sample_idx  <= '0;
         dec_cnt     <= '0;
         wait_cnt    <= '0;
         frame_cnt   <= '0;
         drop_cnt    <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // Decoded from the next state so both outputs line up with the state register
         fft_start <= (state_nxt == ST_START);
         busy      <= (state_nxt != ST_IDLE);

         if (abort || (state == ST_IDLE && arm) || (done_hit && continuous)) begin
            sample_idx <= '0;
            dec_cnt    <= '0;
         end else if (state == ST_FILL && adc_dv) begin
            if (dec_match) begin
               sample_idx <= sample_idx + IDX_W'(1);  // wraps to 0 on the last sample
               dec_cnt    <= '0;
            end else begin
               dec_cnt <= dec_cnt + DEC_W'(1);
            end
         end

         wait_cnt <= (state == ST_WAIT) ? wait_cnt + WT_W'(1) : '0;

         if (done_hit) begin
            frame_cnt <= frame_cnt + 8'd1;
         end

         if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end

         // A new event in the same cycle as clear_err keeps the flag set
         if (drop) begin
            overrun <= 1'b1;
         end else if (clear_err) begin
            overrun <= 1'b0;
         end

         if (to_hit && !abort) begin
            timeout_err <= 1'b1;
         end else if (clear_err) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: a vector table for the basic
// frame / drop / abort flow, then directed sequences for multi-cycle cases.
module tb_fft_frame_ctrl;

   logic clk = 1'b0;
   logic rst, arm, continuous, abort, clear_err, adc_dv, fft_done;

   logic       sh_a, st_a, busy_a, ovr_a, to_a;
   logic [2:0] idx_a;
   logic [7:0] frm_a, drp_a;
   logic       sh_b, st_b, busy_b, ovr_b, to_b;
   logic [2:0] idx_b;
   logic [7:0] frm_b, drp_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fft_frame_ctrl #(.N_SAMPLES(8), .DECIM(1), .TIMEOUT(16)) dut_a (
      .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .abort(abort),
      .clear_err(clear_err), .adc_dv(adc_dv), .fft_done(fft_done),
      .shift_en(sh_a), .fft_start(st_a), .busy(busy_a), .sample_idx(idx_a),
      .frame_cnt(frm_a), .drop_cnt(drp_a), .overrun(ovr_a), .timeout_err(to_a)
   );

   fft_frame_ctrl #(.N_SAMPLES(8), .DECIM(3), .TIMEOUT(16)) dut_b (
      .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .abort(abort),
      .clear_err(clear_err), .adc_dv(adc_dv), .fft_done(fft_done),
      .shift_en(sh_b), .fft_start(st_b), .busy(busy_b), .sample_idx(idx_b),
      .frame_cnt(frm_b), .drop_cnt(drp_b), .overrun(ovr_b), .timeout_err(to_b)
   );

   typedef struct {
      logic arm, dv, done, cont, abrt, clr;
      logic sh, busy, start;
      int   idx, frame, drop;
      logic ovr, to;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      arm = 0; adc_dv = 0; fft_done = 0; abort = 0; clear_err = 0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   task automatic run_cycles(input int n, input logic dv);
      for (int i = 0; i < n; i++) begin
         adc_dv = dv;
         cyc();
      end
      adc_dv = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pulses, misal, nacc;
      //                arm dv dn ct ab cl | sh bs st idx frm drp ovr to
      tbl[0]  = '{0,1,0,0,0,0, 0,0,0, 0,0,0, 0,0};  // dv ignored in idle
      tbl[1]  = '{1,0,0,0,0,0, 0,1,0, 0,0,0, 0,0};  // arm -> FILL
      tbl[2]  = '{0,1,0,0,0,0, 1,1,0, 1,0,0, 0,0};
      tbl[3]  = '{0,1,0,0,0,0, 1,1,0, 2,0,0, 0,0};
      tbl[4]  = '{0,1,0,0,0,0, 1,1,0, 3,0,0, 0,0};
      tbl[5]  = '{0,1,0,0,0,0, 1,1,0, 4,0,0, 0,0};
      tbl[6]  = '{0,1,0,0,0,0, 1,1,0, 5,0,0, 0,0};
      tbl[7]  = '{0,1,0,0,0,0, 1,1,0, 6,0,0, 0,0};
      tbl[8]  = '{0,1,0,0,0,0, 1,1,0, 7,0,0, 0,0};
      tbl[9]  = '{0,1,0,0,0,0, 1,1,1, 0,0,0, 0,0};  // 8th sample -> START
      tbl[10] = '{0,1,0,0,0,0, 0,1,0, 0,0,1, 1,0};  // dv in START is a drop
      tbl[11] = '{0,1,0,0,0,0, 0,1,0, 0,0,2, 1,0};  // dv in WAIT is a drop
      tbl[12] = '{0,1,1,1,0,0, 0,1,0, 0,1,3, 1,0};  // done+dv: drop, refill
      tbl[13] = '{0,1,0,1,0,1, 1,1,0, 1,1,3, 0,0};  // clear_err keeps drop_cnt
      tbl[14] = '{0,1,0,0,1,0, 0,0,0, 0,1,3, 0,0};  // abort wins over dv
      tbl[15] = '{1,1,0,0,0,0, 0,1,0, 0,1,3, 0,0};  // arm from idle, dv ignored
      tbl[16] = '{1,1,0,0,0,0, 1,1,0, 1,1,3, 0,0};  // arm ignored in FILL

      quiet();
      continuous = 0;
      rst = 1;
      cyc();
      chk("rst_shift_en", sh_a, 0);
      chk("rst_fft_start", st_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_sample_idx", idx_a, 0);
      chk("rst_frame_cnt", frm_a, 0);
      chk("rst_drop_cnt", drp_a, 0);
      chk("rst_overrun", ovr_a, 0);
      chk("rst_timeout_err", to_a, 0);
      rst = 0;

      // Vector table
      for (int r = 0; r < 17; r++) begin
         arm = tbl[r].arm; adc_dv = tbl[r].dv; fft_done = tbl[r].done;
         continuous = tbl[r].cont; abort = tbl[r].abrt; clear_err = tbl[r].clr;
         #1;
         chk($sformatf("tbl%0d_shift_en", r), sh_a, tbl[r].sh);
         cyc();
         chk($sformatf("tbl%0d_busy", r), busy_a, tbl[r].busy);
         chk($sformatf("tbl%0d_fft_start", r), st_a, tbl[r].start);
         chk($sformatf("tbl%0d_sample_idx", r), idx_a, tbl[r].idx);
         chk($sformatf("tbl%0d_frame_cnt", r), frm_a, tbl[r].frame);
         chk($sformatf("tbl%0d_drop_cnt", r), drp_a, tbl[r].drop);
         chk($sformatf("tbl%0d_overrun", r), ovr_a, tbl[r].ovr);
         chk($sformatf("tbl%0d_timeout_err", r), to_a, tbl[r].to);
      end
      quiet();
      continuous = 0;

      // Single frame, dv every 4 cycles
      do_reset();
      arm = 1; cyc(); arm = 0;
      chk("single_busy_after_arm", busy_a, 1);
      pulses = 0; misal = 0;
      for (int i = 0; i <= 28; i++) begin
         adc_dv = (i % 4 == 0);
         #1;
         if (sh_a !== adc_dv) misal++;
         if (sh_a) pulses++;
         cyc();
      end
      adc_dv = 0;
      chk("single_pulses", pulses, 8);
      chk("single_misaligned", misal, 0);
      chk("single_fft_start", st_a, 1);
      cyc();
      chk("single_start_one_cycle", st_a, 0);
      chk("single_busy_wait", busy_a, 1);
      run_cycles(8, 0);
      fft_done = 1; cyc(); fft_done = 0;
      chk("single_frame_cnt", frm_a, 1);
      chk("single_busy_done", busy_a, 0);

      // Decimation by 3 on dut_b, dv every other cycle
      do_reset();
      arm = 1; cyc(); arm = 0;
      nacc = 0;
      for (int n = 1; n <= 24; n++) begin
         adc_dv = 1;
         #1;
         chk($sformatf("decim_dv%0d_shift_en", n), sh_b, (n % 3 == 0) ? 1 : 0);
         if (sh_b) nacc++;
         cyc();
         adc_dv = 0;
         if (n == 24) chk("decim_fft_start", st_b, 1);
         else if (n % 3 == 0) chk($sformatf("decim_dv%0d_idx", n), idx_b, n / 3);
         cyc();
      end
      chk("decim_accepted", nacc, 8);

      // Timeout, then done on the last allowed cycle
      do_reset();
      arm = 1; cyc(); arm = 0;
      run_cycles(8, 1);
      chk("to_start", st_a, 1);
      cyc();
      run_cycles(15, 0);
      chk("to_busy_w15", busy_a, 1);
      chk("to_err_w15", to_a, 0);
      cyc();
      chk("to_busy_w16", busy_a, 0);
      chk("to_err_w16", to_a, 1);
      chk("to_frame_cnt", frm_a, 0);
      clear_err = 1; cyc(); clear_err = 0;
      chk("to_cleared", to_a, 0);
      arm = 1; cyc(); arm = 0;
      run_cycles(8, 1);
      cyc();
      run_cycles(15, 0);
      fft_done = 1; cyc(); fft_done = 0;
      chk("to_done_wins_frame", frm_a, 1);
      chk("to_done_wins_err", to_a, 0);
      chk("to_done_wins_busy", busy_a, 0);

      // Abort mid-frame, re-arm, reset during WAIT
      do_reset();
      arm = 1; cyc(); arm = 0;
      run_cycles(5, 1);
      chk("abort_idx_before", idx_a, 5);
      abort = 1; adc_dv = 1;
      #1;
      chk("abort_shift_en", sh_a, 0);
      cyc();
      abort = 0; adc_dv = 0;
      chk("abort_busy", busy_a, 0);
      chk("abort_idx", idx_a, 0);
      arm = 1; cyc(); arm = 0;
      run_cycles(7, 1);
      chk("rearm_idx7", idx_a, 7);
      chk("rearm_no_start", st_a, 0);
      run_cycles(1, 1);
      chk("rearm_start", st_a, 1);
      cyc();
      run_cycles(1, 1);
      chk("wait_drop", drp_a, 1);
      rst = 1; adc_dv = 1;
      cyc();
      chk("wrst_shift_en", sh_a, 0);
      chk("wrst_busy", busy_a, 0);
      chk("wrst_fft_start", st_a, 0);
      chk("wrst_idx", idx_a, 0);
      chk("wrst_frame", frm_a, 0);
      chk("wrst_drop", drp_a, 0);
      chk("wrst_overrun", ovr_a, 0);
      chk("wrst_timeout", to_a, 0);
      rst = 0; adc_dv = 0;

      // Continuous frames: clear_err vs drop, frame_cnt wrap
      do_reset();
      continuous = 1;
      arm = 1; cyc(); arm = 0;
      for (int f = 0; f < 256; f++) begin
         run_cycles(8, 1);
         cyc();
         if (f == 0) begin
            adc_dv = 1; clear_err = 1; cyc(); adc_dv = 0; clear_err = 0;
            chk("clr_vs_drop_overrun", ovr_a, 1);
            chk("clr_vs_drop_cnt", drp_a, 1);
         end
         fft_done = 1; cyc(); fft_done = 0;
         if (f == 254) chk("wrap_frame255", frm_a, 255);
         if (f == 255) chk("wrap_frame0", frm_a, 0);
      end
      chk("wrap_busy_fill", busy_a, 1);
      continuous = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
